// File: rtl/pattern_detector_param.sv
// Serial pattern detector with a loadable PAT_W-bit pattern, selectable
// overlapping/non-overlapping matching and a saturating match counter.
// The newest serial bit enters hist[0]; pat[PAT_W-1] is the oldest bit.
module pattern_detector_param #(
    parameter int                 PAT_W     = 3,
    parameter logic [PAT_W-1:0]   RESET_PAT = PAT_W'(3'b101),
    parameter int                 CNT_W     = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             din,
    input  logic             overlap,
    input  logic             pat_load,
    input  logic [PAT_W-1:0] pat_in,
    input  logic             cnt_clr,
    output logic             dout,
    output logic [CNT_W-1:0] match_cnt,
    output logic             cnt_sat,
    output logic             armed
);

    localparam int FILL_W = $clog2(PAT_W + 1);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

    typedef enum logic {
        FILL  = 1'b0,
        ARMED = 1'b1
    } state_t;

    state_t             state, state_next;
    logic [FILL_W-1:0]  fill, fill_next, fill_inc;
    logic [PAT_W-1:0]   hist, hist_next, hist_shift;
    logic [PAT_W-1:0]   pat, pat_next;
    logic [CNT_W-1:0]   cnt_next;
    logic               sat_next;
    logic               match;

    // Next-state logic: history shift, fill tracking, pattern load and match detection.
    always_comb begin
        // NOTE: every signal gets a default before any branch so no path leaves
        // it unassigned; otherwise synthesis infers a latch to hold the old value.
        hist_next  = hist;
        fill_next  = fill;
        pat_next   = pat;
        match      = 1'b0;
        hist_shift = {hist[PAT_W-2:0], din};
        fill_inc   = (fill == FILL_FULL) ? fill : fill + FILL_W'(1);

        if (pat_load) begin
            // A load restarts matching from scratch; this cycle's sample is dropped.
            pat_next  = pat_in;
            hist_next = '0;
            fill_next = '0;
        end else if (en) begin
            hist_next = hist_shift;
            fill_next = fill_inc;
            match     = (hist_shift == pat) && (fill_inc == FILL_FULL);
            // Non-overlapping mode needs PAT_W fresh samples before the next match.
            if (match && !overlap) begin
                fill_next = '0;
            end
        end

        state_next = (fill_next == FILL_FULL) ? ARMED : FILL;
    end

    // Counter next-state: clear wins over hold, but a coincident match still counts.
    always_comb begin
        cnt_next = match_cnt;
        sat_next = cnt_sat;
        if (cnt_clr) begin
            cnt_next = match ? CNT_W'(1) : '0;
            sat_next = 1'b0;
        end else if (match) begin
            if (match_cnt != CNT_MAX) begin
                cnt_next = match_cnt + CNT_W'(1);
            end
            sat_next = cnt_sat | (cnt_next == CNT_MAX);
        end
    end

    // State register with synchronous active-low reset; all outputs come from here.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples the pre-edge values, independent of statement order.
        if (!rst_n) begin
            state     <= FILL;
            fill      <= '0;
            hist      <= '0;
            pat       <= RESET_PAT;
            dout      <= 1'b0;
            match_cnt <= '0;
            cnt_sat   <= 1'b0;
        end else begin
            state     <= state_next;
            fill      <= fill_next;
            hist      <= hist_next;
            pat       <= pat_next;
            dout      <= match;
            match_cnt <= cnt_next;
            cnt_sat   <= sat_next;
        end
    end

    assign armed = (state == ARMED);

endmodule

// File: tb/tb_pattern_detector_param.sv
// Directed-vector bench for pattern_detector_param. A default instance covers
// matching, loading and reset; a CNT_W=2 instance sharing the same inputs covers
// counter saturation and clear.
module tb_pattern_detector_param;

    logic       clk = 1'b0;
    logic       rst_n, en, din, overlap, pat_load, cnt_clr;
    logic [2:0] pat_in;

    logic       dout, cnt_sat, armed;
    logic [7:0] match_cnt;
    logic       dout2, cnt_sat2, armed2;
    logic [1:0] match_cnt2;

    int checks   = 0;
    int failures = 0;

    pattern_detector_param dut (
        .clk(clk), .rst_n(rst_n), .en(en), .din(din), .overlap(overlap),
        .pat_load(pat_load), .pat_in(pat_in), .cnt_clr(cnt_clr),
        .dout(dout), .match_cnt(match_cnt), .cnt_sat(cnt_sat), .armed(armed)
    );

    pattern_detector_param #(.CNT_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .en(en), .din(din), .overlap(overlap),
        .pat_load(pat_load), .pat_in(pat_in), .cnt_clr(cnt_clr),
        .dout(dout2), .match_cnt(match_cnt2), .cnt_sat(cnt_sat2), .armed(armed2)
    );

    // 100 MHz-style free-running clock.
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Apply one input cycle, then sample 1 time unit after the edge.
    task automatic step(input logic e, input logic d);
        en  = e;
        din = d;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; en = 1'b0; din = 1'b0; pat_load = 1'b0; cnt_clr = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b0; din = 1'b0; overlap = 1'b1;
        pat_load = 1'b0; pat_in = 3'b000; cnt_clr = 1'b0;
        #2;

        // Reset overrides en, pat_load and cnt_clr in the same cycle.
        en = 1'b1; din = 1'b1; pat_load = 1'b1; pat_in = 3'b111; cnt_clr = 1'b1;
        @(posedge clk);
        #1;
        check("rst_dout", dout, 0);
        check("rst_cnt", match_cnt, 0);
        check("rst_sat", cnt_sat, 0);
        check("rst_armed", armed, 0);
        check("rst_fill", dut.fill, 0);
        pat_load = 1'b0; cnt_clr = 1'b0; rst_n = 1'b1;

        // Default pattern 101, overlapping: pulses after bits 3 and 5.
        overlap = 1'b1;
        step(1, 1); check("ov_b1_dout", dout, 0);
        step(1, 0); check("ov_b2_armed", armed, 0);
        step(1, 1); check("ov_b3_dout", dout, 1); check("ov_b3_armed", armed, 1);
        step(1, 0); check("ov_b4_dout", dout, 0);
        step(1, 1); check("ov_b5_dout", dout, 1);
        check("ov_cnt", match_cnt, 2);

        // A reset glitch between edges must not be seen.
        rst_n = 1'b0; #2; rst_n = 1'b1;
        step(0, 1);
        check("glitch_cnt", match_cnt, 2);
        check("glitch_armed", armed, 1);
        check("en0_dout", dout, 0);

        // Same stream, non-overlapping: a single pulse after bit 3.
        do_reset();
        overlap = 1'b0;
        step(1, 1); step(1, 0);
        step(1, 1); check("nov_b3_dout", dout, 1); check("nov_b3_armed", armed, 0);
        step(1, 0); check("nov_b4_dout", dout, 0);
        step(1, 1); check("nov_b5_dout", dout, 0);
        check("nov_cnt", match_cnt, 1);
        check("nov_fill", dut.fill, 2);

        // Load 110 (sample in the load cycle discarded), then bits with en gaps.
        do_reset();
        overlap = 1'b1;
        pat_load = 1'b1; pat_in = 3'b110;
        step(1, 1);
        pat_load = 1'b0;
        check("load_fill", dut.fill, 0);
        check("load_armed", armed, 0);
        step(1, 1); check("gap_fill1", dut.fill, 1);
        step(0, 1); check("gap_en0_a", dout, 0);
        step(1, 1);
        step(0, 0); check("gap_en0_b", dout, 0);
        step(1, 0); check("gap_hit", dout, 1);
        step(0, 0); check("gap_after", dout, 0);
        check("gap_cnt", match_cnt, 1);

        // Load 011 on the cycle that would complete 110: no pulse, new pattern next.
        step(1, 1); step(1, 1);
        pat_load = 1'b1; pat_in = 3'b011;
        step(1, 0);
        pat_load = 1'b0;
        check("ld_cmp_dout", dout, 0);
        check("ld_cmp_fill", dut.fill, 0);
        check("ld_cmp_armed", armed, 0);
        step(1, 0);
        step(1, 1); check("newpat_b2", dout, 0);
        step(1, 1); check("newpat_hit", dout, 1);
        check("newpat_cnt", match_cnt, 2);

        // Reset mid-pattern discards the partial match 1,0.
        do_reset();
        overlap = 1'b1;
        step(1, 1); step(1, 0);
        rst_n = 1'b0;
        step(1, 1);
        check("mid_rst_dout", dout, 0);
        check("mid_rst_cnt", match_cnt, 0);
        check("mid_rst_sat", cnt_sat, 0);
        check("mid_rst_armed", armed, 0);
        rst_n = 1'b1;
        step(1, 1);
        check("post_rst_dout", dout, 0);
        check("post_rst_fill", dut.fill, 1);
        step(1, 0);
        step(1, 1); check("post_rst_hit", dout, 1);

        // Saturation on the CNT_W=2 instance: pattern 111, seven ones.
        do_reset();
        pat_load = 1'b1; pat_in = 3'b111;
        step(0, 0);
        pat_load = 1'b0;
        overlap = 1'b1;
        for (int i = 0; i < 7; i++) begin
            step(1, 1);
            if (i >= 2) check($sformatf("sat_cnt_%0d", i), match_cnt2, (i - 1 > 3) ? 3 : i - 1);
        end
        check("sat_flag", cnt_sat2, 1);
        check("sat_dout", dout2, 1);
        cnt_clr = 1'b1;
        step(1, 1);
        cnt_clr = 1'b0;
        check("clr_hit_cnt", match_cnt2, 1);
        check("clr_hit_sat", cnt_sat2, 0);
        check("clr_hit_dout", dout2, 1);
        check("clr_hit_cnt_w8", match_cnt, 1);
        step(0, 0);
        check("clr_hold_cnt", match_cnt2, 1);
        check("clr_hold_sat", cnt_sat2, 0);
        check("clr_hold_dout", dout2, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pattern_detector_param.md
PATTERN_DETECTOR_PARAM -- requirements
Module: pattern_detector_param

Interface
REQ-001 Parameter PAT_W, default 3, pattern length in bits; legal range 2..16.
REQ-002 Parameter RESET_PAT, default 3'b101, PAT_W-bit pattern loaded at reset.
REQ-003 Parameter CNT_W, default 8, match counter width; legal range 1..32.
REQ-004 Port clk  input  1  sole clock; all state updates on rising edge.
REQ-005 Port rst_n  input  1  reset, synchronous, active-low.
REQ-006 Port en  input  1  din sample valid this cycle.
REQ-007 Port din  input  1  serial data bit, newest bit enters hist[0].
REQ-008 Port overlap  input  1  1 = overlapping matches allowed, 0 = non-overlapping.
REQ-009 Port pat_load  input  1  load new pattern this cycle.
REQ-010 Port pat_in  input  PAT_W  pattern to load; pat_in[PAT_W-1] is the oldest (first-received) bit.
REQ-011 Port cnt_clr  input  1  clear match counter and saturation flag.
REQ-012 Port dout  output  1  registered match pulse (Moore output).
REQ-013 Port match_cnt  output  CNT_W  number of matches since reset/clear, saturating.
REQ-014 Port cnt_sat  output  1  sticky flag, match_cnt reached all-ones.
REQ-015 Port armed  output  1  high when fill == PAT_W (enough history to match).

Function
REQ-016 Internal state: pat register (PAT_W), hist shift register (PAT_W), fill counter (0..PAT_W).
REQ-017 Control states: FILL (fill < PAT_W) and ARMED (fill == PAT_W); armed output = (state == ARMED).
REQ-018 en=1, pat_load=0: hist <= {hist[PAT_W-2:0], din}; fill <= min(fill+1, PAT_W).
REQ-019 en=0, pat_load=0: hist, fill unchanged; dout <= 0.
REQ-020 Match condition: en=1, pat_load=0, updated hist == pat, updated fill == PAT_W.
REQ-021 dout <= match condition; dout high for exactly the one cycle following the edge that samples the final pattern bit.
REQ-022 overlap=1 on match: fill stays PAT_W; next match possible on the very next sampled bit.
REQ-023 overlap=0 on match: fill <= 0 (FILL state); next match needs PAT_W fresh samples.
REQ-024 overlap is sampled each cycle; a change affects only matches from that cycle on.
REQ-025 pat_load=1: pat <= pat_in, hist <= 0, fill <= 0, dout <= 0; any en sample that cycle is discarded.
REQ-026 match_cnt increments by 1 per match; at all-ones it holds and cnt_sat <= 1.
REQ-027 cnt_sat remains set until cnt_clr or reset.
REQ-028 cnt_clr=1: match_cnt <= 0, cnt_sat <= 0; with simultaneous match, match_cnt <= 1 instead.
REQ-029 All outputs registered; no combinational path input-to-output.

Reset
REQ-030 rst_n=0 at rising edge: pat <= RESET_PAT, hist <= 0, fill <= 0, dout <= 0, match_cnt <= 0, cnt_sat <= 0.
REQ-031 Reset overrides en, pat_load, cnt_clr in same cycle; in-progress partial match is discarded.
REQ-032 Asynchronous rst_n edges between clock edges have no effect.

Verification
REQ-033 Defaults, overlap=1, en=1, din 1,0,1,0,1 -> dout pulses after 3rd and 5th bit; match_cnt=2.
REQ-034 Same stream, overlap=0 -> single pulse after 3rd bit; match_cnt=1; armed low after match.
REQ-035 pat_load pat_in=3'b110, then din 1,1,0 with en gaps (en=0 between bits) -> one pulse after 3rd sampled bit only; no pulse on en=0 cycles.
REQ-036 CNT_W=2, overlap=1, pattern 3'b111, din all ones for 7 bits -> match_cnt 1,2,3,3,3; cnt_sat=1; cnt_clr coincident with match -> match_cnt=1, cnt_sat=0.
REQ-037 rst_n=0 after din 1,0 (mid-pattern), release, then din 1 -> no pulse; fill=1; all outputs at reset values during reset.
REQ-038 pat_load asserted on cycle completing old pattern -> no pulse, fill=0, new pat active next cycle.
